mdu_hilo: RTL and testbench

- Iterative multiply/divide unit that owns the HI and LO architectural registers of the multi-cycle MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives HI_Q and LO_Q directly into the write-back data selector, which serves MFHI/MFLO.
- Asserts busy so the control FSM stalls until a result is committed.

---
 rtl/cpu_defs.sv | 32 +++
 rtl/mdu_divider.sv | 31 +++
 rtl/mdu_hilo.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encoding, iteration count and a magnitude helper.
package cpu_defs;

    localparam int MDU_ITERS = 32;
    localparam int MDU_CNT_W = 5;

    typedef enum logic [2:0] {
        MDU_NONE   = 3'b000,
        MDU_MULT   = 3'b001,
        MDU_MULTU  = 3'b010,
        MDU_DIV    = 3'b011,
        MDU_DIVU   = 3'b100,
        MDU_MTHI   = 3'b101,
        MDU_MTLO   = 3'b110,
        MDU_NONE_7 = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// One radix-2 restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, and shift the
// resulting quotient bit into the low end of the quotient register.
module mdu_divider (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic        fits;
    logic [31:0] sub;

    // Trial subtraction; the true difference is always below 2^32 when it
    // fits, so a 32-bit subtract is exact.
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        fits    = (shifted >= {1'b0, divisor_i});
        sub     = shifted[31:0] - divisor_i;
        if (fits) begin
            rem_o = sub;
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Optional build macro MDU_FAST_MULT_EN: MULT/MULTU complete with a single
// 64-bit multiply (IDLE -> FIX) instead of 32 shift-add iterations.
//
// Handshake: start is sampled only while busy=0 (state IDLE). busy is high
// from the edge that accepts a MULT/MULTU/DIV/DIVU until the edge that
// commits HI/LO; done pulses for the single cycle after that commit, and
// HI_Q/LO_Q already hold the result during it. MTHI/MTLO write at the
// accepting edge and never raise busy or done.
module mdu_hilo
    import cpu_defs::*;
#(
    parameter int ITERS = MDU_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI_Q,
    output logic [31:0] LO_Q,
    output logic        busy,
    output logic        done,
    output mdu_state_e  state_dbg
);

    localparam logic [MDU_CNT_W-1:0] LAST_CNT = MDU_CNT_W'(ITERS - 1);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]          acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {rem, quo}
    logic [31:0]          opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [31:0]          a_orig_q, a_orig_d;
    logic                 neg_lo_q, neg_lo_d; // product / quotient sign
    logic                 neg_hi_q, neg_hi_d; // remainder sign
    logic                 is_div_q, is_div_d;
    logic                 div_zero_q, div_zero_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic                 done_q, done_d;

    logic        op_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [31:0] div_rem, div_quo;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign op_signed = (MDU_op == MDU_MULT) || (MDU_op == MDU_DIV);
    assign mag_a     = op_signed ? abs32(A) : A;
    assign mag_b     = op_signed ? abs32(B) : B;

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
    end

    mdu_divider u_div (
        .rem_i     (acc_q[63:32]),
        .quo_i     (acc_q[31:0]),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Sign correction applied to the unsigned magnitude result in FIX.
    always_comb begin
        prod_fix = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        a_orig_d   = a_orig_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDU_op)
                        MDU_MULT, MDU_MULTU: begin
                            neg_lo_d   = op_signed & (A[31] ^ B[31]);
                            neg_hi_d   = 1'b0;
                            is_div_d   = 1'b0;
                            div_zero_d = 1'b0;
`ifdef MDU_FAST_MULT_EN
                            acc_d      = {32'd0, mag_a} * {32'd0, mag_b};
                            state_d    = FIX;
`else
                            acc_d      = {32'd0, mag_b};
                            opb_d      = mag_a;
                            cnt_d      = '0;
                            state_d    = MUL;
`endif
                        end
                        MDU_DIV, MDU_DIVU: begin
                            acc_d      = {32'd0, mag_a};
                            opb_d      = mag_b;
                            a_orig_d   = A;
                            neg_lo_d   = op_signed & (A[31] ^ B[31]);
                            neg_hi_d   = op_signed & A[31];
                            is_div_d   = 1'b1;
                            div_zero_d = (B == 32'd0);
                            cnt_d      = '0;
                            state_d    = DIV;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            DIV: begin
                acc_d = {div_rem, div_quo};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    if (div_zero_q) begin
                        hi_d = a_orig_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            a_orig_q   <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            a_orig_q   <= a_orig_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign HI_Q      = hi_q;
    assign LO_Q      = lo_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases, an ignored mid-flight
// start, reset abort, and randomized operations against a plain-arithmetic
// reference model. Honors MDU_FAST_MULT_EN for expected multiply timing.
module tb_mdu_hilo;
    import cpu_defs::*;

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI_Q;
    logic [31:0] LO_Q;
    logic        busy;
    logic        done;
    mdu_state_e  state_dbg;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_hilo dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .MDU_op    (MDU_op),
        .A         (A),
        .B         (B),
        .HI_Q      (HI_Q),
        .LO_Q      (LO_Q),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] start_cyc;
        logic [7:0]  lat;
        logic [7:0]  busy_len;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {HI, LO} after the operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                r  = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MDU_MTHI:  return {a, model_lo};
            MDU_MTLO:  return {model_hi, a};
            default:   return {model_hi, model_lo};
        endcase
    endfunction

    function automatic bit is_mult(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic bit is_long(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // ---------------- monitor ----------------
    task automatic monitor();
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (busy) run++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("hilo_result", {HI_Q, LO_Q}, {e.hi, e.lo});
                        check("done_latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                        check("busy_cycles", 64'(run), 64'(e.busy_len));
                        check("busy_low_at_done", 64'(busy), 64'd0);
                    end
                    run = 0;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic push_expect(input logic [2:0] op, input logic [63:0] r);
        exp_t e;
        e.hi        = r[63:32];
        e.lo        = r[31:0];
        e.start_cyc = cyc;
        e.lat       = (FAST && is_mult(op)) ? 8'd2 : 8'd34;
        e.busy_len  = (FAST && is_mult(op)) ? 8'd1 : 8'd33;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        @(negedge clk);
        r      = ref_result(op, a, b);
        start  = 1'b1;
        MDU_op = op;
        A      = a;
        B      = b;
        if (is_long(op)) begin
            push_expect(op, r);
            model_hi = r[63:32];
            model_lo = r[31:0];
            @(negedge clk);
            start  = 1'b0;
            MDU_op = MDU_NONE;
            wait_drain();
        end else begin
            @(posedge clk);
            #1;
            model_hi = r[63:32];
            model_lo = r[31:0];
            check("short_op_hi", 64'(HI_Q), 64'(model_hi));
            check("short_op_lo", 64'(LO_Q), 64'(model_lo));
            check("short_op_busy", 64'(busy), 64'd0);
            start  = 1'b0;
            MDU_op = MDU_NONE;
            @(negedge clk);
            check("short_op_done", 64'(done), 64'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] old_hi, old_lo;
        logic [2:0]  long_op;

        rst    = 1'b1;
        start  = 1'b0;
        MDU_op = MDU_NONE;
        A      = 32'd0;
        B      = 32'd0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_hi", 64'(HI_Q), 64'd0);
        check("reset_lo", 64'(LO_Q), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        rst = 1'b0;

        // Directed cases
        issue(MDU_MULT,  32'hFFFF_FFFD, 32'd7);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(MDU_DIVU,  32'd7,         32'd2);
        issue(MDU_DIV,   32'h1234_5678, 32'd0);
        issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(MDU_DIVU,  32'hCAFE_0001, 32'd0);
        issue(MDU_MULT,  32'h8000_0000, 32'h8000_0000);
        issue(MDU_DIV,   32'd100,       32'hFFFF_FFF9);
        issue(MDU_MTHI,  32'hDEAD_BEEF, 32'd0);
        issue(MDU_MTLO,  32'h0BAD_F00D, 32'd0);
        issue(MDU_NONE,  32'h1111_1111, 32'd3);
        issue(MDU_NONE_7, 32'h2222_2222, 32'd3);

        // A start while busy is ignored and the in-flight op completes intact.
        long_op = FAST ? MDU_DIV : MDU_MULT;
        old_hi  = model_hi;
        old_lo  = model_lo;
        @(negedge clk);
        start  = 1'b1;
        MDU_op = long_op;
        A      = 32'hFFFF_F000;
        B      = 32'h0000_1235;
        push_expect(long_op, ref_result(long_op, 32'hFFFF_F000, 32'h0000_1235));
        {model_hi, model_lo} = ref_result(long_op, 32'hFFFF_F000, 32'h0000_1235);
        @(negedge clk);
        start  = 1'b0;
        MDU_op = MDU_NONE;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        MDU_op = MDU_DIVU;
        A      = 32'd7;
        B      = 32'd2;
        @(negedge clk);
        start  = 1'b0;
        MDU_op = MDU_NONE;
        check("hold_hi_in_flight", 64'(HI_Q), 64'(old_hi));
        check("hold_lo_in_flight", 64'(LO_Q), 64'(old_lo));
        wait_drain();

        // Reset in the middle of a DIV aborts it.
        @(negedge clk);
        start  = 1'b1;
        MDU_op = MDU_DIV;
        A      = 32'h7654_3210;
        B      = 32'd13;
        @(negedge clk);
        start  = 1'b0;
        MDU_op = MDU_NONE;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_hi", 64'(HI_Q), 64'd0);
        check("abort_lo", 64'(LO_Q), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_state", 64'(state_dbg), 64'(IDLE));
        rst      = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (40) @(negedge clk);
        check("abort_no_late_done", 64'(exp_q.size()), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            issue(op, a, b);
        end

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
